// File: rtl/sirv_spi_slave_pkg.sv
// Shared opcodes, FSM state encoding and read fill pattern for the SPI-slave-to-ICB bridge.
package sirv_spi_slave_pkg;
  localparam logic [7:0]  OP_WRITE = 8'h02;
  localparam logic [7:0]  OP_READ  = 8'h03;
  localparam logic [31:0] RD_FILL  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, WR_ISSUE, DUMMY, RDATA, IGNORE
  } state_t;
endpackage

// File: rtl/sirv_spi_slave_sync.sv
// Multi-flop synchronizer with a configurable preset value applied on asynchronous reset.
module sirv_spi_slave_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/sirv_spi_slave_icb.sv
// SPI mode-0 slave that turns write (0x02) / read (0x03) frames into single ICB transactions.
module sirv_spi_slave_icb
  import sirv_spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_port_sck,
  input  logic        io_port_cs_0,
  input  logic        io_port_dq_0_i,
  output logic        io_port_dq_1_o,
  output logic        io_port_dq_1_oe,
  output logic        o_icb_cmd_valid,
  input  logic        o_icb_cmd_ready,
  output logic [31:0] o_icb_cmd_addr,
  output logic        o_icb_cmd_read,
  output logic [31:0] o_icb_cmd_wdata,
  input  logic        o_icb_rsp_valid,
  output logic        o_icb_rsp_ready,
  input  logic [31:0] o_icb_rsp_rdata
);
  logic sck_s, cs_s, mosi_s, sck_d, cs_d;

  sirv_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clock), .rst(reset), .d(io_port_sck), .q(sck_s));
  sirv_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clock), .rst(reset), .d(io_port_cs_0), .q(cs_s));
  sirv_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clock), .rst(reset), .d(io_port_dq_0_i), .q(mosi_s));

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] sr, sr_next, rd_shift;
  logic        is_read, rsp_got, outstanding, late;

  assign sr_next         = {sr[30:0], mosi_s};
  assign o_icb_rsp_ready = 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_d <= 1'b0;  cs_d <= 1'b1;
      state <= IDLE;  cnt <= '0;  sr <= '0;  rd_shift <= '0;
      is_read <= 1'b0;  rsp_got <= 1'b0;  outstanding <= 1'b0;  late <= 1'b0;
      o_icb_cmd_valid <= 1'b0;  o_icb_cmd_read <= 1'b0;
      o_icb_cmd_addr <= '0;  o_icb_cmd_wdata <= '0;
      io_port_dq_1_o <= 1'b0;  io_port_dq_1_oe <= 1'b0;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
      // The handshake and response complete independently of the FSM, so an abort never strands them.
      if (o_icb_cmd_valid && o_icb_cmd_ready) o_icb_cmd_valid <= 1'b0;
      if (o_icb_rsp_valid) outstanding <= 1'b0;
      if (o_icb_rsp_valid && outstanding && state == DUMMY && !rsp_got) begin
        rd_shift <= o_icb_rsp_rdata;
        rsp_got  <= 1'b1;
      end

      if (cs_rise) begin
        state <= IDLE;
        io_port_dq_1_o  <= 1'b0;
        io_port_dq_1_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            cnt <= '0;  sr <= '0;  late <= 1'b0;  rsp_got <= 1'b0;
            state <= outstanding ? IGNORE : CMD;
          end
          CMD: if (sck_rise) begin
            sr <= sr_next;
            if (cnt == 6'd7) begin
              cnt <= '0;
              case (sr_next[7:0])
                OP_WRITE: begin is_read <= 1'b0; state <= ADDR; end
                OP_READ:  begin is_read <= 1'b1; state <= ADDR; end
                default:  state <= IGNORE;
              endcase
            end else cnt <= cnt + 6'd1;
          end
          ADDR: if (sck_rise) begin
            sr <= sr_next;
            if (cnt == 6'd31) begin
              cnt <= '0;
              o_icb_cmd_addr <= sr_next;
              if (is_read) begin
                o_icb_cmd_valid <= 1'b1;  o_icb_cmd_read <= 1'b1;  outstanding <= 1'b1;
                state <= DUMMY;
              end else state <= WDATA;
            end else cnt <= cnt + 6'd1;
          end
          WDATA: if (sck_rise) begin
            sr <= sr_next;
            if (cnt == 6'd31) begin
              cnt <= '0;
              o_icb_cmd_wdata <= sr_next;
              o_icb_cmd_valid <= 1'b1;  o_icb_cmd_read <= 1'b0;  outstanding <= 1'b1;
              state <= WR_ISSUE;
            end else cnt <= cnt + 6'd1;
          end
          WR_ISSUE: if (o_icb_cmd_valid && o_icb_cmd_ready) state <= IGNORE;
          DUMMY: begin
            if (sck_rise && cnt != 6'd8) cnt <= cnt + 6'd1;
            else if (sck_fall && cnt == 6'd8) begin
              // Bit 31 goes out on this fall; cnt then tracks bits already driven.
              cnt <= 6'd1;
              io_port_dq_1_oe <= 1'b1;
              state <= RDATA;
              if (rsp_got) begin
                io_port_dq_1_o <= rd_shift[31];
                rd_shift <= {rd_shift[30:0], 1'b0};
              end else begin
                io_port_dq_1_o <= RD_FILL[31];
                rd_shift <= {RD_FILL[30:0], 1'b0};
                late <= 1'b1;
              end
            end
          end
          RDATA: if (sck_fall) begin
            if (cnt == 6'd32) begin
              io_port_dq_1_o  <= 1'b0;
              io_port_dq_1_oe <= 1'b0;
              state <= IGNORE;
            end else begin
              io_port_dq_1_o <= rd_shift[31];
              rd_shift <= {rd_shift[30:0], 1'b0};
              cnt <= cnt + 6'd1;
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sirv_spi_slave_icb.sv
// Directed bench: SPI master frames against a small ICB responder, with hand-computed expectations.
module tb_sirv_spi_slave_icb;
  import sirv_spi_slave_pkg::*;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset, sck, cs, mosi;
  logic        miso, oe;
  logic        cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;

  int          checks = 0, errors = 0;
  int          cmd_count = 0, oe_seen = 0, rsp_delay = 2;
  logic        rsp_hold = 1'b0;
  logic [31:0] rdata_val = '0, rec_addr = '0, rec_wdata = '0;
  logic        rec_read = 1'b0;
  logic [31:0] rx, junk;

  sirv_spi_slave_icb #(.SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset),
    .io_port_sck(sck), .io_port_cs_0(cs), .io_port_dq_0_i(mosi),
    .io_port_dq_1_o(miso), .io_port_dq_1_oe(oe),
    .o_icb_cmd_valid(cmd_valid), .o_icb_cmd_ready(cmd_ready),
    .o_icb_cmd_addr(cmd_addr), .o_icb_cmd_read(cmd_read), .o_icb_cmd_wdata(cmd_wdata),
    .o_icb_rsp_valid(rsp_valid), .o_icb_rsp_ready(rsp_ready), .o_icb_rsp_rdata(rsp_rdata)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ICB target: records each handshake and returns one response after a delay.
  initial begin : responder
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    forever begin
      @(negedge clock);
      if (!reset && cmd_valid && cmd_ready) begin
        cmd_count++;
        rec_addr = cmd_addr;  rec_wdata = cmd_wdata;  rec_read = cmd_read;
        repeat (rsp_delay) @(negedge clock);
        while (rsp_hold) @(negedge clock);
        rsp_valid = 1'b1;
        rsp_rdata = rdata_val;
        @(negedge clock);
        rsp_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic xfer(input logic [31:0] val, input int n, output logic [31:0] rxv);
    rxv = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      repeat (HALF) @(negedge clock);
      sck = 1'b1;
      rxv = {rxv[30:0], miso};
      if (oe) oe_seen++;
      repeat (HALF) @(negedge clock);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    oe_seen = 0;
    cs = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clock);
    cs = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  int base, held;

  initial begin : main
    reset = 1'b1;  sck = 1'b0;  cs = 1'b1;  mosi = 1'b0;  cmd_ready = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_addr",  cmd_addr, 0);
    check_eq("rst_oe",    oe, 0);
    check_eq("rst_rsp_ready", rsp_ready, 1);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Write frame
    rdata_val = 32'h0;
    cs_low();
    xfer(32'h02, 8, junk);  xfer(32'h1000_0014, 32, junk);  xfer(32'hDEAD_BEEF, 32, junk);
    repeat (10) @(negedge clock);
    cs_high();
    check_eq("wr_count", cmd_count, 1);
    check_eq("wr_addr",  rec_addr, 32'h1000_0014);
    check_eq("wr_wdata", rec_wdata, 32'hDEAD_BEEF);
    check_eq("wr_read",  rec_read, 0);
    check_eq("wr_valid_low", cmd_valid, 0);

    // Read frame with prompt response
    rdata_val = 32'hCAFE_F00D;
    cs_low();
    xfer(32'h03, 8, junk);  xfer(32'h1000_0018, 32, junk);  xfer(32'h0, 8, junk);
    xfer(32'h0, 32, rx);
    check_eq("rd_oe_periods", oe_seen, 32);
    cs_high();
    check_eq("rd_miso", rx, 32'hCAFE_F00D);
    check_eq("rd_addr", rec_addr, 32'h1000_0018);
    check_eq("rd_read", rec_read, 1);
    check_eq("rd_oe_after", oe, 0);

    // Late read: response withheld past the dummy byte
    rsp_hold = 1'b1;  rdata_val = 32'h1234_5678;
    cs_low();
    xfer(32'h03, 8, junk);  xfer(32'h1000_001C, 32, junk);  xfer(32'h0, 8, junk);
    xfer(32'h0, 32, rx);
    cs_high();
    check_eq("late_miso", rx, 32'hFFFF_FFFF);
    check_eq("late_flag", dut.late, 1);
    rsp_hold = 1'b0;
    repeat (20) @(negedge clock);
    check_eq("late_sticky", dut.late, 1);

    // Bad opcode; also confirms the late flag clears on frame start
    base = cmd_count;
    cs_low();
    check_eq("late_cleared", dut.late, 0);
    xfer(32'h9F, 8, junk);  xfer(32'h0, 32, junk);  xfer(32'h0, 8, junk);
    check_eq("bad_state", 32'(dut.state), 32'(IGNORE));
    cs_high();
    check_eq("bad_no_cmd", cmd_count, base);
    check_eq("bad_oe", oe_seen, 0);

    // Abort after 20 address bits
    cs_low();
    xfer(32'h03, 8, junk);  xfer(32'hABCDE, 20, junk);
    cs_high();
    check_eq("abort_addr_state", 32'(dut.state), 32'(IDLE));
    check_eq("abort_addr_valid", cmd_valid, 0);
    check_eq("abort_addr_count", cmd_count, base);

    // Abort in DUMMY with the command stalled for 10 clocks
    cmd_ready = 1'b0;  rsp_hold = 1'b1;
    cs_low();
    xfer(32'h03, 8, junk);  xfer(32'h2000_0000, 32, junk);  xfer(32'h0, 3, junk);
    cs_high();
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (cmd_valid && cmd_read && cmd_addr == 32'h2000_0000) held++;
    end
    check_eq("abort_dummy_held", held, 10);
    @(posedge clock);  #1 cmd_ready = 1'b1;
    @(posedge clock);  @(negedge clock);
    check_eq("abort_dummy_drop", cmd_valid, 0);
    check_eq("abort_dummy_once", cmd_count, base + 1);
    check_eq("abort_dummy_oe", oe_seen, 0);
    cs_low();
    xfer(32'h02, 8, junk);  xfer(32'h30, 32, junk);  xfer(32'h55, 32, junk);
    cs_high();
    check_eq("blocked_count", cmd_count, base + 1);
    rsp_hold = 1'b0;
    repeat (10) @(negedge clock);
    cs_low();
    xfer(32'h02, 8, junk);  xfer(32'h30, 32, junk);  xfer(32'h55, 32, junk);
    repeat (10) @(negedge clock);
    cs_high();
    check_eq("after_rsp_count", cmd_count, base + 2);
    check_eq("after_rsp_wdata", rec_wdata, 32'h55);

    // Reset in the middle of WDATA
    repeat (10) @(negedge clock);
    cs_low();
    xfer(32'h02, 8, junk);  xfer(32'h1234_5678, 32, junk);  xfer(32'hFFFF, 16, junk);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_addr",  cmd_addr, 0);
    check_eq("mid_rst_wdata", cmd_wdata, 0);
    check_eq("mid_rst_valid", cmd_valid, 0);
    check_eq("mid_rst_read",  cmd_read, 0);
    check_eq("mid_rst_miso",  miso, 0);
    check_eq("mid_rst_oe",    oe, 0);
    cs = 1'b1;  sck = 1'b0;  mosi = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    cs_low();
    xfer(32'h02, 8, junk);  xfer(32'h0, 32, junk);  xfer(32'h1, 32, junk);
    repeat (10) @(negedge clock);
    cs_high();
    check_eq("post_rst_count", cmd_count, base + 3);
    check_eq("post_rst_addr",  rec_addr, 0);
    check_eq("post_rst_wdata", rec_wdata, 1);
    check_eq("post_rst_read",  rec_read, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sirv_spi_slave_icb.md
SIRV_SPI_SLAVE_ICB -- requirements
Module: sirv_spi_slave_icb

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sck, cs and MOSI inputs.
REQ-002 SHALL have port clock, input, 1: single system clock for all logic.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port io_port_sck, input, 1: SPI clock from the external master, mode 0.
REQ-005 SHALL have port io_port_cs_0, input, 1: chip select, active low.
REQ-006 SHALL have port io_port_dq_0_i, input, 1: MOSI.
REQ-007 SHALL have port io_port_dq_1_o, output, 1: MISO.
REQ-008 SHALL have port io_port_dq_1_oe, output, 1: MISO output enable.
REQ-009 SHALL have ports o_icb_cmd_valid (output, 1) and o_icb_cmd_ready (input, 1): ICB command handshake.
REQ-010 SHALL have ports o_icb_cmd_addr (output, 32), o_icb_cmd_read (output, 1) and o_icb_cmd_wdata (output, 32): ICB command payload.
REQ-011 SHALL have ports o_icb_rsp_valid (input, 1), o_icb_rsp_ready (output, 1) and o_icb_rsp_rdata (input, 32): ICB response channel.

Function
REQ-012 SHALL pass sck, cs and MOSI through SYNC_STAGES flops, then detect sck rise and fall edges; clock SHALL be at least 8x sck.
REQ-013 SHALL sample MOSI on sck rise and update MISO on sck fall; all fields SHALL be MSB first.
REQ-014 SHALL implement states IDLE, CMD, ADDR, WDATA, WR_ISSUE, DUMMY, RDATA and IGNORE.
REQ-015 SHALL move IDLE->CMD on synchronized cs falling; if an ICB transaction is outstanding, it SHALL move IDLE->IGNORE instead.
REQ-016 SHALL move from CMD after 8 bits: 0x02->ADDR(write), 0x03->ADDR(read), any other value->IGNORE.
REQ-017 SHALL move from ADDR after 32 bits: write->WDATA; read->DUMMY, asserting o_icb_cmd_valid with read=1 on the next clock.
REQ-018 SHALL move WDATA->WR_ISSUE after 32 bits, asserting o_icb_cmd_valid with read=0 and the captured address/wdata.
REQ-019 SHALL hold o_icb_cmd_valid and its payload stable until o_icb_cmd_ready is sampled high; valid SHALL drop on the cycle after the handshake.
REQ-020 SHALL tie o_icb_rsp_ready to 1; on read, o_icb_rsp_rdata SHALL be latched into the shift register when o_icb_rsp_valid is high.
REQ-021 SHALL move DUMMY->RDATA on the sck fall after the 8th dummy rise and drive bit 31 on that fall.
REQ-022 SHALL, if no read response has been captured by the transition of REQ-021, shift out 32'hFFFF_FFFF and set the sticky internal late flag, which clears on the next frame start.
REQ-023 SHALL shift one bit per sck fall in RDATA; after 32 bits it SHALL go to IGNORE.
REQ-024 SHALL drive io_port_dq_1_oe high only in RDATA while cs is low; otherwise io_port_dq_1_o=0 and oe=0.
REQ-025 SHALL abort from any state to IDLE on synchronized cs rising.
REQ-026 SHALL, on the abort of REQ-025, complete an already-asserted ICB command handshake and its response; no new command SHALL issue until the response arrives.
REQ-027 SHALL stay in WR_ISSUE until the handshake and then go to IGNORE; extra sck bits SHALL be ignored until cs rises.
REQ-028 SHALL have at most one ICB transaction outstanding.

Reset
REQ-029 SHALL on reset go to IDLE, clear all counters and shift registers, and set o_icb_cmd_valid=0, o_icb_cmd_read=0, addr=0, wdata=0, io_port_dq_1_o=0 and io_port_dq_1_oe=0; o_icb_rsp_ready SHALL be 1.
REQ-030 SHALL preset the synchronizer flops to sck=0, cs=1 and MOSI=0 on reset.

Structure
REQ-031 SHALL place the command opcodes (0x02, 0x03), state encodings and the 32'hFFFF_FFFF fill constant in a shared package, sirv_spi_slave_pkg.
REQ-032 SHALL use one sub-module, sirv_spi_slave_sync: a parameterized SYNC_STAGES synchronizer instantiated per input; everything else stays in a single FSM/datapath.

Verification
REQ-033 SHALL cover write: frame 02, 1000_0014, DEADBEEF with ready held 1 -> one cmd, addr=0x10000014, wdata=0xDEADBEEF, read=0.
REQ-034 SHALL cover read: frame 03, 1000_0018, dummy, 32 clocks with rsp rdata=0xCAFEF00D within 4 clocks -> MISO shows 0xCAFEF00D and oe high exactly 32 sck periods.
REQ-035 SHALL cover a late read: rsp_valid withheld until after dummy -> MISO shows 0xFFFFFFFF and the late flag is set.
REQ-036 SHALL cover a bad opcode: command 0x9F followed by 40 sck -> no ICB cmd and oe stays 0.
REQ-037 SHALL cover aborts: cs raised after 20 address bits -> no cmd, IDLE; cs raised during DUMMY with ready=0 for 10 clocks -> valid held, completes once, and the next frame proceeds only after the response.
REQ-038 SHALL cover mid-write reset: reset asserted mid-WDATA -> all outputs at reset values asynchronously, and the next frame 02, 0, 1 is accepted normally.
